// File: rtl/stb_pkg.sv
// Store-buffer shared types.
//   stb_entry_t : one buffered store, word address plus data
//   STB_AW/DW   : address/data widths the entry layout is built for
//   clog2()     : pointer width for a given buffer depth
package stb_pkg;
    localparam int STB_AW = 32;
    localparam int STB_DW = 32;

    // Only the word address is kept; addr[1:0] never matters for sw.
    typedef struct packed {
        logic [STB_AW-3:0] addr;
        logic [STB_DW-1:0] data;
    } stb_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/store_buffer_fifo.sv
// In-order circular FIFO holding buffered stores.
//   clk, rst   : clock, async active-low reset (pointers/count only)
//   push, pop  : enqueue wr_entry at tail / retire head (ignored if full/empty)
//   entries    : raw storage, indexed by slot, for the forwarding compare
//   head       : slot of the oldest entry
//   count      : number of valid entries (0..DEPTH)
//   full/empty : count==DEPTH / count==0
module store_buffer_fifo
    import stb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  stb_entry_t             wr_entry,
    output stb_entry_t [DEPTH-1:0] entries,
    output logic [PW-1:0]          head,
    output logic [PW:0]            count,
    output logic                   full,
    output logic                   empty
);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    stb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]          tail;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign entries = mem;

    // Storage is deliberately not reset; count alone defines validity.
    always_ff @(posedge clk)
        if (do_push) mem[tail] <= wr_entry;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core M stage and dmem.
// Stores retire into a FIFO and drain one per cycle whenever the port is not
// taken by a load. Loads keep priority on the dmem port.
// Build option: define STB_FWD_EN to forward buffered data to matching loads;
// without it a matching load stalls until the matching entries have drained.
// Ports:
//   clk, rst                     : clock, async active-low reset
//   mem_write, mem_read_m        : M-stage store / load request
//   data_addr_m, write_data_m    : M-stage byte address, store data
//   read_data_m                  : load data to core (combinational)
//   stall_m                      : hold M stage this cycle
//   stb_empty                    : nothing buffered
//   dmem_we, dmem_addr, dmem_wd  : dmem write/address port
//   dmem_rd                      : dmem combinational read data
module dmem_store_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = STB_AW,
    parameter int DW    = STB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_write,
    input  logic          mem_read_m,
    input  logic [AW-1:0] data_addr_m,
    input  logic [DW-1:0] write_data_m,
    output logic [DW-1:0] read_data_m,
    output logic          stall_m,
    output logic          stb_empty,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wd,
    input  logic [DW-1:0] dmem_rd
);
    localparam int PW = clog2(DEPTH);

    stb_entry_t [DEPTH-1:0] entries;
    stb_entry_t             wr_entry;
    stb_entry_t             head_entry;
    logic [PW-1:0]          head;
    logic [PW-1:0]          slot;
    logic [PW:0]            count;
    logic                   full;
    logic                   empty;
    logic                   load;
    logic                   hit;
    logic                   ld_block;
    logic                   push;
    logic                   pop;
`ifdef STB_FWD_EN
    logic [DW-1:0]          fwd_data;
`endif

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .entries  (entries),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign wr_entry.addr = data_addr_m[AW-1:2];
    assign wr_entry.data = write_data_m;
    assign head_entry    = entries[head];

    // A simultaneous store wins; the read only keeps the port from draining.
    assign load = mem_read_m & ~mem_write;

    // Walk valid entries oldest to youngest so the last match is the youngest.
    always_comb begin
        hit  = 1'b0;
        slot = head;
`ifdef STB_FWD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (((PW+1)'(k) < count) && (entries[slot].addr == data_addr_m[AW-1:2])) begin
                hit = 1'b1;
`ifdef STB_FWD_EN
                fwd_data = entries[slot].data;
`endif
            end
        end
    end

`ifdef STB_FWD_EN
    assign ld_block    = 1'b0;
    assign read_data_m = (load & hit) ? fwd_data : dmem_rd;
`else
    // Stale memory would be read: hold the load and let the buffer drain.
    assign ld_block    = load & hit;
    assign read_data_m = dmem_rd;
`endif

    // Full stalls even when a drain frees a slot this cycle: the stall
    // must not depend on the drain decision.
    assign stall_m = (mem_write & full) | ld_block;
    assign push    = mem_write & ~stall_m;
    assign pop     = ~empty & (~mem_read_m | ld_block);

    assign stb_empty = empty;
    assign dmem_we   = pop;
    assign dmem_addr = pop ? {head_entry.addr, 2'b00} : data_addr_m;
    assign dmem_wd   = head_entry.data;
endmodule
